// File: rtl/unidade_despacho_tomasulo.sv
// Tomasulo dispatch stage: allocates a free reservation station, resolves operands
// against the register result-status table (Qi) with same-cycle CDB bypass.
module unidade_despacho_tomasulo #(
    parameter int                 NUM_REGS        = 8,
    parameter int                 NUM_RS          = 4,
    parameter int                 TAG_W           = 3,
    parameter int                 DATA_W          = 16,
    parameter logic [DATA_W-1:0]  VJ_VK_SEM_VALOR = 16'hFFF0
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Inst_Valid,
    input  logic [15:0]                  Inst,
    output logic                         Inst_Ready,
    input  logic [NUM_REGS*DATA_W-1:0]   Reg_Data,
    input  logic [NUM_RS-1:0]            RS_Busy,
    input  logic                         CDB_Valid,
    input  logic [TAG_W-1:0]             CDB_Tag,
    input  logic [DATA_W-1:0]            CDB_Data,
    output logic                         Disp_Valid,
    output logic [TAG_W-1:0]             Disp_RS,
    output logic [2:0]                   Disp_Op,
    output logic [2:0]                   Disp_Dest,
    output logic [DATA_W-1:0]            Vj,
    output logic [DATA_W-1:0]            Vk,
    output logic [TAG_W-1:0]             Qj,
    output logic [TAG_W-1:0]             Qk,
    output logic [NUM_REGS*TAG_W-1:0]    Qi_Flat
);

    typedef struct packed {
        logic [DATA_W-1:0] v;
        logic [TAG_W-1:0]  q;
    } operand_t;

    logic [TAG_W-1:0]  qi [NUM_REGS];
    logic [NUM_RS-1:0] pend;
    logic [NUM_RS-1:0] free_mask;
    logic [TAG_W-1:0]  alloc_tag;
    logic              accept;
    operand_t          op_j;
    operand_t          op_k;

    logic [2:0] op_f, ri, rj, rk;
    logic       unused_inst_bits;

    assign op_f = Inst[15:13];
    assign ri   = Inst[12:10];
    assign rj   = Inst[8:6];
    assign rk   = Inst[5:3];
    assign unused_inst_bits = ^{Inst[9], Inst[2:0]};

    function automatic operand_t resolve(input logic [TAG_W-1:0] q,
                                         input logic [DATA_W-1:0] reg_value,
                                         input logic cdb_valid,
                                         input logic [TAG_W-1:0] cdb_tag,
                                         input logic [DATA_W-1:0] cdb_data);
        operand_t res;
        if (q == '0) begin
            res.v = reg_value;
            res.q = '0;
        end else if (cdb_valid && cdb_tag == q) begin
            res.v = cdb_data;
            res.q = '0;
        end else begin
            res.v = VJ_VK_SEM_VALOR;
            res.q = q;
        end
        return res;
    endfunction

    // The station dispatched last cycle has not raised its busy bit yet, so mask it.
    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        pend      = '0;
        alloc_tag = '0;
        for (int i = 0; i < NUM_RS; i++)
            pend[i] = Disp_Valid && (Disp_RS == TAG_W'(i + 1));
        free_mask = ~RS_Busy & ~pend;
        // Descending scan: the last hit is the lowest free index.
        for (int i = NUM_RS - 1; i >= 0; i--)
            if (free_mask[i]) alloc_tag = TAG_W'(i + 1);
    end

    assign Inst_Ready = (|free_mask) && !Reset;
    assign accept     = Inst_Valid && Inst_Ready;

    always_comb begin
        op_j = resolve(qi[rj], Reg_Data[int'(rj)*DATA_W +: DATA_W], CDB_Valid, CDB_Tag, CDB_Data);
        op_k = resolve(qi[rk], Reg_Data[int'(rk)*DATA_W +: DATA_W], CDB_Valid, CDB_Tag, CDB_Data);
    end

    always_comb begin
        Qi_Flat = '0;
        for (int i = 0; i < NUM_REGS; i++)
            Qi_Flat[i*TAG_W +: TAG_W] = qi[i];
    end

    // NOTE: sequential state uses non-blocking assignments; the later qi[ri] write
    // in the same block overrides the CDB clear, which gives dispatch priority.
    // NOTE: the status table is a handful of flops, so it is reset like any register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) qi[i] <= '0;
            Disp_Valid <= 1'b0;
            Disp_RS    <= '0;
            Disp_Op    <= '0;
            Disp_Dest  <= '0;
            Vj         <= VJ_VK_SEM_VALOR;
            Vk         <= VJ_VK_SEM_VALOR;
            Qj         <= '0;
            Qk         <= '0;
        end else begin
            Disp_Valid <= accept;
            if (CDB_Valid && CDB_Tag != '0)
                for (int i = 0; i < NUM_REGS; i++)
                    if (qi[i] == CDB_Tag) qi[i] <= '0;
            if (accept) begin
                Disp_RS   <= alloc_tag;
                Disp_Op   <= op_f;
                Disp_Dest <= ri;
                Vj        <= op_j.v;
                Qj        <= op_j.q;
                Vk        <= op_k.v;
                Qk        <= op_k.q;
                qi[ri]    <= alloc_tag;
            end
        end
    end

endmodule

// File: doc/unidade_despacho_tomasulo.md
# unidade_despacho_tomasulo

Parametrised Tomasulo dispatch stage with an internal register result-status table (Qi per register). Accepts one instruction per cycle from the instruction queue over a valid/ready handshake. Allocates a free reservation station and reads operands as values (Vj/Vk) or producer tags (Qj/Qk), with same-cycle CDB bypass. Sits between the instruction queue and the reservation stations, snooping the common data bus.

## Interface
- NUM_REGS, 8: architectural registers; register fields are 3 bits, so at most 8.
- NUM_RS, 4: reservation stations, tags 1..NUM_RS; tag 0 = FREE_REGISTER (value ready).
- TAG_W, 3: tag width; NUM_RS <= 2^TAG_W-1.
- DATA_W, 16: operand width.
- VJ_VK_SEM_VALOR, 16'hFFF0: filler for Vj/Vk when the operand is pending.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high.
- Inst_Valid  in  1  queue holds an instruction.
- Inst  in  16  opcode [15:13], Ri [12:10], Rj [8:6], Rk [5:3].
- Inst_Ready  out  1  combinational; a station is free and Reset is low.
- Reg_Data  in  NUM_REGS*DATA_W  flat register-bank contents; register n at [n*DATA_W +: DATA_W].
- RS_Busy  in  NUM_RS  busy bit per station; bit i is tag i+1.
- CDB_Valid  in  1  result broadcast this cycle.
- CDB_Tag  in  TAG_W  producing station.
- CDB_Data  in  DATA_W  broadcast value.
- Disp_Valid  out  1  registered one-cycle pulse, dispatch payload valid.
- Disp_RS  out  TAG_W  allocated station tag.
- Disp_Op  out  3  opcode.
- Disp_Dest  out  3  Ri.
- Vj, Vk  out  DATA_W  operand values.
- Qj, Qk  out  TAG_W  operand producer tags; 0 means the value is valid.
- Qi_Flat  out  NUM_REGS*TAG_W  status table for debug and bench checks.

## Operation
- Free mask = ~RS_Busy & ~Pend, where Pend is the one-hot of Disp_RS while Disp_Valid=1. This covers the one-cycle gap before the station raises its busy bit.
- Allocation picks the lowest-index free station.
- Inst_Ready = |free mask.
- Accept when Inst_Valid & Inst_Ready at a rising edge. On accept:
  - Register Disp_Valid=1, Disp_RS, Disp_Op, Disp_Dest.
  - Register Vj/Qj from Rj and Vk/Qk from Rk.
  - Set Qi[Ri] = Disp_RS.
- Operand resolution for register r, using the Qi value from before this edge:
  - Qi[r]==0: V = Reg_Data[r], Q = 0.
  - Qi[r]!=0, and CDB_Valid with CDB_Tag==Qi[r]: V = CDB_Data, Q = 0 (bypass).
  - Otherwise: V = VJ_VK_SEM_VALOR, Q = Qi[r].
- Rj==Rk resolves identically for both operands.
- Ri==Rj or Ri==Rk: sources read the old status, never the new tag.
- CDB snoop: CDB_Valid with CDB_Tag!=0 clears every Qi entry equal to CDB_Tag. CDB_Tag==0 is ignored.
- Same edge, dispatch targeting a register the CDB clears: the dispatch write wins, so Qi[Ri] = new tag.
- R0 has no special meaning.
- No accept: Disp_Valid=0. Vj/Vk/Qj/Qk/Disp_* hold their last values.

## Timing
- Reset (asynchronous, any time): all Qi = 0, Disp_Valid = 0, Disp_RS/Disp_Op/Disp_Dest = 0, Vj/Vk = VJ_VK_SEM_VALOR, Qj/Qk = 0. An instruction being accepted on that edge is dropped.
- Latency: accept at edge t, payload visible from t until t+1.
- Stations latch the payload at edge t+1 and raise RS_Busy from t+1.
- Throughput: one dispatch per cycle while stations remain free.
- Full: all stations busy or pending, so Inst_Ready=0. The queue holds Inst and Inst_Valid.
- Inst_Ready rises in the same cycle RS_Busy drops.
- Qi_Flat reflects the table after each edge.

## Test plan
- Reset, then Reg_Data R1=5, R2=7. Dispatch ADD R3,R1,R2 -> Disp_Valid pulse, Disp_RS=1, Vj=5, Vk=7, Qj=Qk=0, Qi[3]=1.
- Next cycle dispatch R4,R3,R1 with RS_Busy[0] not yet high -> Disp_RS=2 (Pend blocks tag 1), Qj=1, Vj=16'hFFF0, Vk=5.
- Source Qi[3]=1 with CDB_Valid, CDB_Tag=1, CDB_Data=42 on the dispatch edge -> Vj=42, Qj=0, Qi[3] cleared.
- Dispatch writes R3 while the CDB clears tag 1 (Qi[3]=1) on the same edge -> Qi[3]=new tag.
- RS_Busy=4'b1111 with Inst_Valid=1 -> Inst_Ready=0 and no dispatch. Drop RS_Busy[2] -> accept with Disp_RS=3.
- Assert Reset mid-stream with Qi non-zero -> Qi_Flat=0, Disp_Valid=0 immediately; the first post-reset dispatch gets tag 1.
